// File: rtl/pipeline_skeleton_if.sv
// Instruction-fetch bus between the pipeline backbone and a same-cycle instruction memory.
interface pipeline_skeleton_if #(
  parameter int ADDRESS_LEN     = 32,
  parameter int INSTRUCTION_LEN = 32
);
  logic [ADDRESS_LEN-1:0]     imem_addr;
  logic [INSTRUCTION_LEN-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/pipeline_skeleton.sv
// In-order pipeline backbone: PC, fetch addressing, STAGES stage registers {valid, pc, instr},
// freeze / branch-flush control and retire / stall / flush counters.
module pipeline_skeleton #(
  parameter int                     ADDRESS_LEN     = 32,
  parameter int                     INSTRUCTION_LEN = 32,
  parameter int                     STAGES          = 5,
  parameter int                     FREEZE_STAGE    = 0,
  parameter int                     BRANCH_STAGE    = 1,
  parameter int                     PC_STEP         = 4,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0,
  parameter int                     COUNT_W         = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                freeze_req,
  input  logic                                branch_taken,
  input  logic [ADDRESS_LEN-1:0]              branch_addr,
  pipeline_skeleton_if.master                 imem,
  output logic [STAGES-1:0]                   stage_valid,
  output logic [STAGES*ADDRESS_LEN-1:0]       stage_pc,
  output logic [STAGES*INSTRUCTION_LEN-1:0]   stage_instr,
  output logic                                retire_valid,
  output logic [ADDRESS_LEN-1:0]              retire_pc,
  output logic [INSTRUCTION_LEN-1:0]          retire_instr,
  output logic [COUNT_W-1:0]                  retired_count,
  output logic [COUNT_W-1:0]                  stall_count,
  output logic [COUNT_W-1:0]                  flush_count
);

  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic [STAGES-1:0]          valid_q, valid_d;
  logic [ADDRESS_LEN-1:0]     st_pc_q    [STAGES];
  logic [ADDRESS_LEN-1:0]     st_pc_d    [STAGES];
  logic [INSTRUCTION_LEN-1:0] st_instr_q [STAGES];
  logic [INSTRUCTION_LEN-1:0] st_instr_d [STAGES];
  logic [COUNT_W-1:0]         retired_q, retired_d;
  logic [COUNT_W-1:0]         stall_q, stall_d;
  logic [COUNT_W-1:0]         flush_q, flush_d;
  logic                       eff_branch;

  // A taken branch only counts when the branch stage really holds an instruction;
  // it then wins over freeze, so a redirect never waits behind a hazard stall.
  assign eff_branch = branch_taken & valid_q[BRANCH_STAGE];

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    st_pc_d   = st_pc_q;
    st_instr_d = st_instr_q;
    retired_d = retired_q + COUNT_W'(valid_q[STAGES-1]);
    stall_d   = stall_q;
    flush_d   = flush_q;

    if (eff_branch) begin
      pc_d          = branch_addr;
      flush_d       = flush_q + COUNT_W'(1);
      valid_d[0]    = 1'b0;
      st_pc_d[0]    = '0;
      st_instr_d[0] = '0;
    end else if (freeze_req) begin
      stall_d = stall_q + COUNT_W'(1);
    end else begin
      pc_d          = pc_q + ADDRESS_LEN'(PC_STEP);
      valid_d[0]    = 1'b1;
      st_pc_d[0]    = pc_q;
      st_instr_d[0] = imem.imem_rdata;
    end

    for (int s = 1; s < STAGES; s++) begin
      if ((eff_branch && s <= BRANCH_STAGE) ||
          (!eff_branch && freeze_req && s == FREEZE_STAGE + 1)) begin
        valid_d[s]    = 1'b0;
        st_pc_d[s]    = '0;
        st_instr_d[s] = '0;
      end else if (!eff_branch && freeze_req && s <= FREEZE_STAGE) begin
        valid_d[s]    = valid_q[s];
        st_pc_d[s]    = st_pc_q[s];
        st_instr_d[s] = st_instr_q[s];
      end else begin
        valid_d[s]    = valid_q[s-1];
        st_pc_d[s]    = st_pc_q[s-1];
        st_instr_d[s] = st_instr_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      valid_q   <= '0;
      retired_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        st_pc_q[s]    <= '0;
        st_instr_q[s] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      st_pc_q    <= st_pc_d;
      st_instr_q <= st_instr_d;
      retired_q  <= retired_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign imem.imem_addr = pc_q;

  always_comb begin
    stage_pc    = '0;
    stage_instr = '0;
    for (int s = 0; s < STAGES; s++) begin
      stage_pc[s*ADDRESS_LEN +: ADDRESS_LEN]         = st_pc_q[s];
      stage_instr[s*INSTRUCTION_LEN +: INSTRUCTION_LEN] = st_instr_q[s];
    end
  end

  assign stage_valid   = valid_q;
  assign retire_valid  = valid_q[STAGES-1];
  assign retire_pc     = st_pc_q[STAGES-1];
  assign retire_instr  = st_instr_q[STAGES-1];
  assign retired_count = retired_q;
  assign stall_count   = stall_q;
  assign flush_count   = flush_q;

endmodule
